// File: rtl/line_buffer_pkg.sv
// Shared line-buffer configuration, also used by the image-control parent.
//
// Contents:
//   LineWDef, PixWDef, TapsDef - default line length, pixel width and tap count
//   wrap_add()                 - modular add for offsets smaller than the line length
package line_buffer_pkg;

  localparam int unsigned LineWDef = 480;
  localparam int unsigned PixWDef  = 8;
  localparam int unsigned TapsDef  = 6;

  // (base + offs) mod len, assuming base < len and offs <= len. A single conditional
  // subtract avoids a real divider for non-power-of-two line lengths.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned offs,
                                           input int unsigned len);
    int unsigned sum;
    sum = base + offs;
    return (sum >= len) ? sum - len : sum;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel buffer with a sliding window of TAPS consecutive pixels.
//
// Pixels are written at wr_ptr on i_data_valid; the window starts at rd_ptr, which
// advances on i_rd_data. Both pointers wrap at LINE_W. There are no full/empty flags:
// the parent keeps the two pointers in a sensible order.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-high; clears both pointers, keeps memory contents
//   i_data       - pixel to store
//   i_data_valid - write strobe for i_data
//   i_rd_data    - advance the read window by one pixel
//   o_data       - window, o_data[k] = mem[(rd_ptr + k) mod LINE_W]
//
// Build option:
//   LINE_BUFFER_OUT_REG_EN - when defined, o_data is registered (one cycle latency,
//                            cleared on reset); otherwise it is combinational.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int unsigned LINE_W = LineWDef,
  parameter int unsigned PIX_W  = PixWDef,
  parameter int unsigned TAPS   = TapsDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_data_valid,
  input  logic             i_rd_data,
  output logic [PIX_W-1:0] o_data [0:TAPS-1]
);

  localparam int unsigned PtrW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(LINE_W - 1);

  logic [PIX_W-1:0] mem_q [LINE_W];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  rd_idx [TAPS];
  logic [PIX_W-1:0] window_d [TAPS];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_data_valid) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (i_rd_data) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Memory is written straight from the strobe (no full-array next-state) so it maps
  // onto distributed RAM. Reset blocks the write so contents survive a reset.
  always_ff @(posedge clk) begin
    if (i_data_valid && !reset) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // TAPS asynchronous read ports; the index wraps past the end of the line.
  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      rd_idx[k]   = PtrW'(wrap_add(32'(rd_ptr_q), k, LINE_W));
      window_d[k] = mem_q[rd_idx[k]];
    end
  end

`ifdef LINE_BUFFER_OUT_REG_EN
  logic [PIX_W-1:0] out_q [TAPS];

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      if (reset) begin
        out_q[k] <= '0;
      end else begin
        out_q[k] <= window_d[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      o_data[k] = out_q[k];
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      o_data[k] = window_d[k];
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed self-checking bench for line_buffer at its default parameters.
module tb_line_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_rd_data;
  logic [7:0] o_data [0:5];

  int vectors = 0;
  int errs    = 0;

  line_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // One clock with the given strobes; inputs return idle 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rd, input logic rst);
    i_data_valid = v;
    i_data       = d;
    i_rd_data    = rd;
    reset        = rst;
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    reset        = 1'b0;
  endtask

  // With a registered output, an idle cycle lets the register catch up with the window.
  task automatic settle();
`ifdef LINE_BUFFER_OUT_REG_EN
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
`endif
  endtask

  task automatic check_tap(input string tag, input int k, input logic [7:0] exp);
    vectors++;
    assert (o_data[k] === exp)
    else begin
      errs++;
      $error("FAIL %s tap%0d: got %h expected %h", tag, k, o_data[k], exp);
    end
  endtask

  // exp packs taps 0..5 from the MSB down.
  task automatic check_win(input string tag, input logic [47:0] exp);
    logic [47:0] e;
    e = exp;
    for (int k = 0; k < 6; k++) check_tap(tag, k, e[(5-k)*8 +: 8]);
  endtask

  initial begin
    reset        = 1'b1;
    i_data       = 8'h00;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef LINE_BUFFER_OUT_REG_EN
    check_win("reset_out_reg", 48'h00_00_00_00_00_00);
`endif

    // Fill one line, value = index mod 256, no reads
    for (int i = 0; i < 480; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    settle();
    check_win("fill", 48'h00_01_02_03_04_05);

    // Idle cycle holds both pointers
    cycle(1'b0, 8'h99, 1'b0, 1'b0);
    settle();
    check_win("hold", 48'h00_01_02_03_04_05);

    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_win("rd10", 48'h0a_0b_0c_0d_0e_0f);

    // rd_ptr -> 477: window wraps after three taps
    for (int i = 0; i < 467; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_win("wrap477", 48'hdd_de_df_00_01_02);

    // rd_ptr -> 478: tap 2 shows mem[0]
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_win("wrap478", 48'hde_df_00_01_02_03);

    // rd_ptr wraps back to 0
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_win("rdwrap0", 48'h00_01_02_03_04_05);

    // Write-pointer wrap: 481 writes, the last (0xAA) lands at index 0
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 480; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'haa, 1'b0, 1'b0);
    settle();
    check_win("wrwrap", 48'haa_01_02_03_04_05);
    cycle(1'b1, 8'hbb, 1'b0, 1'b0);
    settle();
    check_win("wrnext", 48'haa_bb_02_03_04_05);

    // Simultaneous write to address 0 and read advance from rd_ptr 0
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    settle();
    i_data       = 8'h55;
    i_data_valid = 1'b1;
    i_rd_data    = 1'b1;
    #1;
`ifndef LINE_BUFFER_OUT_REG_EN
    check_tap("same_cycle_old", 0, 8'haa);
`endif
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;
    settle();
    check_win("after_rw", 48'hbb_02_03_04_05_06);

    // Drive to rd_ptr = 100, wr_ptr = 200, rewriting addresses 1..199 with their index
    for (int i = 0; i < 199; i++) cycle(1'b1, 8'(i + 1), (i < 99), 1'b0);
    settle();
    check_win("rd100", 48'h64_65_66_67_68_69);

    // Reset with both strobes: pointers clear, no write to address 200
    cycle(1'b1, 8'hee, 1'b1, 1'b1);
    settle();
    check_win("reset_mid", 48'h55_01_02_03_04_05);

    // Next write lands at address 0
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    settle();
    check_win("wr_after_rst", 48'h77_01_02_03_04_05);

    // Address 200 still holds its old contents
    for (int i = 0; i < 198; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_win("mem_kept", 48'hc6_c7_c8_c9_ca_cb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
